// File: rtl/mc_mv_fetch_if.sv
// Bundle of the fetch command, MV RAM read port and MV output stream of mc_mv_fetch.
// The master modport is the fetch engine; slave is the surrounding control/RAM/MC side.
interface mc_mv_fetch_if #(
    parameter int unsigned FMV_WIDTH  = 10,
    parameter int unsigned IDX_WIDTH  = 6,
    parameter int unsigned BANK_WIDTH = 3
);
    logic                            start_i;
    logic [BANK_WIDTH-1:0]           bank_i;
    logic [IDX_WIDTH:0]              num_i;
    logic                            ram_cen_o;
    logic                            ram_wen_o;
    logic [IDX_WIDTH+BANK_WIDTH-1:0] ram_addr_o;
    logic [2*FMV_WIDTH-1:0]          ram_data_i;
    logic                            mv_valid_o;
    logic                            mv_ready_i;
    logic [FMV_WIDTH-1:0]            mv_x_o;
    logic [FMV_WIDTH-1:0]            mv_y_o;
    logic [IDX_WIDTH-1:0]            mv_idx_o;
    logic                            mv_last_o;
    logic                            busy_o;
    logic                            done_o;

    modport master (
        input  start_i, bank_i, num_i, ram_data_i, mv_ready_i,
        output ram_cen_o, ram_wen_o, ram_addr_o, mv_valid_o, mv_x_o, mv_y_o, mv_idx_o,
               mv_last_o, busy_o, done_o
    );

    modport slave (
        output start_i, bank_i, num_i, ram_data_i, mv_ready_i,
        input  ram_cen_o, ram_wen_o, ram_addr_o, mv_valid_o, mv_x_o, mv_y_o, mv_idx_o,
               mv_last_o, busy_o, done_o
    );
endinterface

// File: rtl/mc_mv_fetch.sv
// Reads NUM consecutive MV words of one bank from the MC MV RAM and streams them as signed
// (x, y) pairs over valid/ready, using a 2-entry buffer to hide read latency and back-pressure.
module mc_mv_fetch #(
    parameter int unsigned FMV_WIDTH  = 10,
    parameter int unsigned IDX_WIDTH  = 6,
    parameter int unsigned BANK_WIDTH = 3
) (
    input logic           clk,
    input logic           rst,
    mc_mv_fetch_if.master bus
);
    localparam int unsigned DataWidth = 2 * FMV_WIDTH;
    localparam int unsigned CntWidth  = IDX_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [BANK_WIDTH-1:0] bank_q;
    logic [CntWidth-1:0]   num_q;
    logic [CntWidth-1:0]   rd_cnt_q;
    logic                  inflight_q;
    logic [IDX_WIDTH-1:0]  inflight_idx_q;
    logic [DataWidth-1:0]  fifo_data_q [2];
    logic [IDX_WIDTH-1:0]  fifo_idx_q  [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;

    logic                 fifo_empty;
    logic                 valid;
    logic                 pop;
    logic                 fifo_pop;
    logic                 push;
    logic                 issue;
    logic                 is_last;
    logic                 last_hs;
    logic [1:0]           occupancy;
    logic [DataWidth-1:0] head_data;
    logic [IDX_WIDTH-1:0] head_idx;

    assign fifo_empty = (count_q == 2'd0);
    assign valid      = !fifo_empty || inflight_q;
    assign pop        = valid && bus.mv_ready_i;

    // With the buffer empty the returning RAM word is offered directly; if it is not taken in
    // that cycle it is captured, so the presented value stays stable under back-pressure.
    assign head_data = fifo_empty ? bus.ram_data_i : fifo_data_q[rd_ptr_q];
    assign head_idx  = fifo_empty ? inflight_idx_q : fifo_idx_q[rd_ptr_q];
    assign fifo_pop  = pop && !fifo_empty;
    assign push      = inflight_q && !(fifo_empty && pop);

    // Entries held or in flight once this cycle's pop is taken; a read needs a free slot.
    assign occupancy = count_q + {1'b0, inflight_q} - {1'b0, pop};
    assign is_last   = ({1'b0, head_idx} == (num_q - CntWidth'(1)));
    assign last_hs   = pop && is_last;

    assign bus.mv_valid_o = valid;
    assign bus.mv_x_o     = valid ? head_data[DataWidth-1:FMV_WIDTH] : '0;
    assign bus.mv_y_o     = valid ? head_data[FMV_WIDTH-1:0] : '0;
    assign bus.mv_idx_o   = valid ? head_idx : '0;
    assign bus.mv_last_o  = valid && is_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    state_d = (bus.num_i != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (issue && ((rd_cnt_q + CntWidth'(1)) == num_q)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (last_hs) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        issue          = (state_q == StRun) && (rd_cnt_q < num_q) && (occupancy < 2'd2);
        bus.ram_cen_o  = !issue;
        bus.ram_wen_o  = 1'b1;
        bus.ram_addr_o = issue ? {bank_q, rd_cnt_q[IDX_WIDTH-1:0]} : '0;
        bus.busy_o     = (state_q != StIdle);
        bus.done_o     = (state_q == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q         <= '0;
            num_q          <= '0;
            rd_cnt_q       <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_idx_q[i]  <= '0;
            end
        end else begin
            if ((state_q == StIdle) && bus.start_i) begin
                bank_q   <= bus.bank_i;
                num_q    <= bus.num_i;
                rd_cnt_q <= '0;
            end else if (issue) begin
                rd_cnt_q <= rd_cnt_q + CntWidth'(1);
            end
            inflight_q <= issue;
            if (issue) begin
                inflight_idx_q <= rd_cnt_q[IDX_WIDTH-1:0];
            end
            if (push) begin
                fifo_data_q[wr_ptr_q] <= bus.ram_data_i;
                fifo_idx_q[wr_ptr_q]  <= inflight_idx_q;
                wr_ptr_q              <= !wr_ptr_q;
            end
            if (fifo_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, fifo_pop};
        end
    end
endmodule
